// File: rtl/mc_alu_sequencer.sv
// mc_alu_sequencer: multi-cycle MIPS main control FSM with memory-wait timeout, retire counter and sticky error flags
module mc_alu_sequencer #(
    parameter int TO_W  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic             mem_timeout
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Counter value on the last tolerated wait cycle; one more idle cycle would reach 2^TO_W-1
    localparam logic [TO_W-1:0] WAIT_LAST = ~TO_W'(1);

    state_t          cur;
    state_t          nxt;
    logic [TO_W-1:0] wait_cnt;
    logic            waiting;
    logic            expire;
    logic            retire;
    logic            bad_op;

    assign state   = cur;
    assign waiting = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    // mem_ready on the limit cycle takes priority over the timeout
    assign expire  = waiting && !mem_ready && (wait_cnt == WAIT_LAST);

    // Next-state selection, retire strobe and unsupported-opcode detection
    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        bad_op = 1'b0;
        case (cur)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_R:         nxt = EXEC;
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_BEQ:       nxt = BEQ;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default: begin
                        nxt    = FETCH;
                        bad_op = 1'b1;
                    end
                endcase
            end
            MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : (expire ? FETCH : MEMRD);
            MEMWR: begin
                nxt    = (mem_ready || expire) ? FETCH : MEMWR;
                retire = mem_ready;
            end
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            MEMWB, ALUWB, BEQ, ADDIWB, JUMP: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

    // Moore control decode; everything held low while reset is asserted
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (reset_n) begin
            case (cur)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                DECODE: alu_src_b = 2'b11;
                MEMADR, ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                ADDIWB: reg_write = 1'b1;
                JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, memory-wait counter, retire counter and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur         <= FETCH;
            wait_cnt    <= '0;
            retired     <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= (waiting && !mem_ready && !expire) ? wait_cnt + TO_W'(1) : '0;
            if (retire) retired <= retired + CNT_W'(1);
            if (bad_op) illegal_op <= 1'b1;
            if (expire) mem_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mc_alu_sequencer.sv
// tb_mc_alu_sequencer: directed scenarios for the multi-cycle control FSM
module tb_mc_alu_sequencer;
    localparam int TO_W  = 3;
    localparam int CNT_W = 4;

    // Control vector layout: mem_read mem_write iord ir_write pc_en pc_src alu_src_a alu_src_b alu_op reg_dst mem_to_reg reg_write
    localparam logic [14:0] C_FRDY   = 15'b1_0_0_1_1_00_0_01_00_0_0_0;
    localparam logic [14:0] C_FWAIT  = 15'b1_0_0_0_0_00_0_01_00_0_0_0;
    localparam logic [14:0] C_DEC    = 15'b0_0_0_0_0_00_0_11_00_0_0_0;
    localparam logic [14:0] C_MADR   = 15'b0_0_0_0_0_00_1_10_00_0_0_0;
    localparam logic [14:0] C_MRD    = 15'b1_0_1_0_0_00_0_00_00_0_0_0;
    localparam logic [14:0] C_MWB    = 15'b0_0_0_0_0_00_0_00_00_0_1_1;
    localparam logic [14:0] C_MWR    = 15'b0_1_1_0_0_00_0_00_00_0_0_0;
    localparam logic [14:0] C_EXEC   = 15'b0_0_0_0_0_00_1_00_10_0_0_0;
    localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_00_0_00_00_1_0_1;
    localparam logic [14:0] C_BEQT   = 15'b0_0_0_0_1_01_1_00_01_0_0_0;
    localparam logic [14:0] C_BEQN   = 15'b0_0_0_0_0_01_1_00_01_0_0_0;
    localparam logic [14:0] C_ADDIWB = 15'b0_0_0_0_0_00_0_00_00_0_0_1;
    localparam logic [14:0] C_JUMP   = 15'b0_0_0_0_1_10_0_00_00_0_0_0;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [5:0]       opcode = 6'b0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_read, mem_write, iord, ir_write, pc_en, alu_src_a;
    logic             reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] exp_ret;
    logic [14:0]      ctl;
    int               vectors = 0;
    int               miscompares = 0;

    assign ctl = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write};

    always #5 clk = ~clk;

    mc_alu_sequencer #(.TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state(state),
        .retired(retired), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (ctl !== 15'b0 || state !== 4'd0) begin
            $display("FAIL reset_outputs: state=%0d ctl=%b, want state=0 ctl=0", state, ctl); miscompares++;
        end
        vectors++;
        if (retired !== 4'd0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
            $display("FAIL reset_regs: retired=%0d ill=%b to=%b, want 0 0 0", retired, illegal_op, mem_timeout); miscompares++;
        end
        @(negedge clk);
        reset_n = 1'b1; zero = 1'b0; exp_ret = '0;
    endtask

    task automatic test_rtype();
        logic [3:0]  es[4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [14:0] ec[4] = '{C_FRDY, C_DEC, C_EXEC, C_ALUWB};
        opcode = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                $display("FAIL rtype c%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]); miscompares++;
            end
            @(negedge clk);
        end
        exp_ret++; #1; vectors++;
        if (state !== 4'd0 || retired !== exp_ret) begin
            $display("FAIL rtype_retire: state=%0d retired=%0d, want 0 %0d", state, retired, exp_ret); miscompares++;
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  es[8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [14:0] ec[8] = '{C_FRDY, C_DEC, C_MADR, C_MRD, C_MRD, C_MRD, C_MRD, C_MWB};
        logic        mr[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i]; #1; vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                $display("FAIL lw c%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]); miscompares++;
            end
            @(negedge clk);
        end
        exp_ret++; #1; vectors++;
        if (state !== 4'd0 || retired !== exp_ret) begin
            $display("FAIL lw_retire: state=%0d retired=%0d, want 0 %0d", state, retired, exp_ret); miscompares++;
        end
    endtask

    task automatic test_beq();
        logic [3:0]  es[3] = '{4'd0, 4'd1, 4'd8};
        logic [14:0] ec[3];
        opcode = 6'b000100; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            ec = '{C_FRDY, C_DEC, z[0] ? C_BEQT : C_BEQN};
            for (int i = 0; i < 3; i++) begin
                #1; vectors++;
                if (state !== es[i] || ctl !== ec[i]) begin
                    $display("FAIL beq z%0d c%0d: state=%0d ctl=%b, want state=%0d ctl=%b", z, i, state, ctl, es[i], ec[i]); miscompares++;
                end
                @(negedge clk);
            end
            exp_ret++; #1; vectors++;
            if (state !== 4'd0 || retired !== exp_ret) begin
                $display("FAIL beq_retire z%0d: state=%0d retired=%0d, want 0 %0d", z, state, retired, exp_ret); miscompares++;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_addi_jump();
        logic [3:0]  ea[4] = '{4'd0, 4'd1, 4'd9, 4'd10};
        logic [14:0] ca[4] = '{C_FRDY, C_DEC, C_MADR, C_ADDIWB};
        logic [3:0]  ej[3] = '{4'd0, 4'd1, 4'd11};
        logic [14:0] cj[3] = '{C_FRDY, C_DEC, C_JUMP};
        opcode = 6'b001000; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; vectors++;
            if (state !== ea[i] || ctl !== ca[i]) begin
                $display("FAIL addi c%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, ea[i], ca[i]); miscompares++;
            end
            @(negedge clk);
        end
        opcode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            #1; vectors++;
            if (state !== ej[i] || ctl !== cj[i]) begin
                $display("FAIL jump c%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, ej[i], cj[i]); miscompares++;
            end
            @(negedge clk);
        end
        exp_ret += 2; #1; vectors++;
        if (state !== 4'd0 || retired !== exp_ret) begin
            $display("FAIL addi_jump_retire: state=%0d retired=%0d, want 0 %0d", state, retired, exp_ret); miscompares++;
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        @(negedge clk); #1; vectors++;
        if (state !== 4'd1 || illegal_op !== 1'b0) begin
            $display("FAIL illegal_decode: state=%0d ill=%b, want 1 0", state, illegal_op); miscompares++;
        end
        @(negedge clk); #1; vectors++;
        if (state !== 4'd0 || illegal_op !== 1'b1 || retired !== exp_ret) begin
            $display("FAIL illegal_flag: state=%0d ill=%b retired=%0d, want 0 1 %0d", state, illegal_op, retired, exp_ret); miscompares++;
        end
        opcode = 6'b000010;
        repeat (3) @(negedge clk);
        exp_ret++; #1; vectors++;
        if (illegal_op !== 1'b1 || retired !== exp_ret) begin
            $display("FAIL illegal_sticky: ill=%b retired=%0d, want 1 %0d", illegal_op, retired, exp_ret); miscompares++;
        end
    endtask

    task automatic test_timeout();
        logic [3:0]  es[10] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        logic [14:0] ec[10] = '{C_FRDY, C_DEC, C_MADR, C_MWR, C_MWR, C_MWR, C_MWR, C_MWR, C_MWR, C_MWR};
        opcode = 6'b101011;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) begin
                mem_ready = (i == 0) || (i == 9 && p == 0); #1; vectors++;
                if (state !== es[i] || ctl !== ec[i]) begin
                    $display("FAIL sw p%0d c%0d: state=%0d ctl=%b, want state=%0d ctl=%b", p, i, state, ctl, es[i], ec[i]); miscompares++;
                end
                @(negedge clk);
            end
            if (p == 0) exp_ret++;
            #1; vectors++;
            if (state !== 4'd0 || retired !== exp_ret || mem_timeout !== p[0]) begin
                $display("FAIL sw_end p%0d: state=%0d retired=%0d to=%b, want 0 %0d %0d", p, state, retired, mem_timeout, exp_ret, p); miscompares++;
            end
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1; vectors++;
            if (state !== 4'd0 || ctl !== C_FWAIT) begin
                $display("FAIL fetch_wait c%0d: state=%0d ctl=%b, want state=0 ctl=%b", i, state, ctl, C_FWAIT); miscompares++;
            end
            @(negedge clk);
        end
        opcode = 6'b000010; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_ret++; #1; vectors++;
        if (state !== 4'd0 || retired !== exp_ret || mem_timeout !== 1'b1) begin
            $display("FAIL fetch_recover: state=%0d retired=%0d to=%b, want 0 %0d 1", state, retired, mem_timeout, exp_ret); miscompares++;
        end
    endtask

    task automatic test_async_reset();
        opcode = 6'b100011; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1; vectors++;
        if (state !== 4'd3 || ctl !== C_MRD) begin
            $display("FAIL pre_reset: state=%0d ctl=%b, want state=3 ctl=%b", state, ctl, C_MRD); miscompares++;
        end
        #1 reset_n = 1'b0;
        #1; vectors++;
        if (state !== 4'd0 || ctl !== 15'b0 || retired !== 4'd0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
            $display("FAIL async_reset: state=%0d ctl=%b ret=%0d ill=%b to=%b, want all 0", state, ctl, retired, illegal_op, mem_timeout); miscompares++;
        end
        @(negedge clk);
        reset_n = 1'b1; exp_ret = '0;
        #1; vectors++;
        if (state !== 4'd0 || ctl !== C_FWAIT || retired !== 4'd0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
            $display("FAIL reset_release: state=%0d ctl=%b ret=%0d ill=%b to=%b, want 0 %b 0 0 0", state, ctl, retired, illegal_op, mem_timeout, C_FWAIT); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        opcode = 6'b000010; mem_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            repeat (2) @(negedge clk);
            #1; vectors++;
            if (state !== 4'd11 || ctl !== C_JUMP) begin
                $display("FAIL wrap_jump n%0d: state=%0d ctl=%b, want state=11 ctl=%b", n, state, ctl, C_JUMP); miscompares++;
            end
            @(negedge clk);
            exp_ret++; #1; vectors++;
            if (retired !== exp_ret) begin
                $display("FAIL wrap_count n%0d: retired=%0d, want %0d", n, retired, exp_ret); miscompares++;
            end
        end
        vectors++;
        if (retired !== 4'd0) begin
            $display("FAIL wrap_zero: retired=%0d, want 0", retired); miscompares++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_addi_jump();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
